// File: rtl/rt_timer_scan.sv
`default_nettype none
// ============================================================================
// Module   : rt_timer_scan
// Brief    : Per-flow retransmit timer. Keeps an armed bit and a deadline per
//            flow, advances a prescaled tick counter and scans one flow per
//            cycle, emitting a one-cycle timeout pulse on expiry.
// Revision : 1.0 - initial release
// ============================================================================
module rt_timer_scan #(
  parameter int MAX_FLOW_CNT = 64,
  parameter int FLOWID_W     = $clog2(MAX_FLOW_CNT),
  parameter int TIMER_W      = 16,
  parameter int TICK_DIV     = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arm_val,
  input  logic [FLOWID_W-1:0] arm_flowid,
  input  logic [TIMER_W-1:0]  arm_timeout,
  input  logic                disarm_val,
  input  logic [FLOWID_W-1:0] disarm_flowid,
  input  logic                new_flow_val,
  input  logic [FLOWID_W-1:0] new_flow_flowid,
  output logic                timeout_set_bit_val,
  output logic [FLOWID_W-1:0] timeout_set_bit_flowid,
  output logic [TIMER_W-1:0]  now_tick
);

  // A single-cycle prescaler still needs a 1-bit counter that sits at zero.
  localparam int              C_DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(TICK_DIV - 1);

  logic [C_DIV_W-1:0]      r_div_cnt;
  logic [TIMER_W-1:0]      r_now_tick;
  logic [FLOWID_W-1:0]     r_scan_ptr;
  logic [MAX_FLOW_CNT-1:0] r_armed;
  logic [TIMER_W-1:0]      r_deadline [MAX_FLOW_CNT];
  logic                    r_to_val;
  logic [FLOWID_W-1:0]     r_to_flowid;

  logic [TIMER_W-1:0]      w_scan_deadline;
  logic [TIMER_W-1:0]      w_age;
  logic                    w_scan_touched;
  logic                    w_expire;
  logic [MAX_FLOW_CNT-1:0] w_armed_nxt;

  // Prescaler and tick counter; the tick wraps naturally at 2^TIMER_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt  <= '0;
      r_now_tick <= '0;
    end else if (r_div_cnt == C_DIV_LAST) begin
      r_div_cnt  <= '0;
      r_now_tick <= r_now_tick + 1'b1;
    end else begin
      r_div_cnt  <= r_div_cnt + 1'b1;
    end
  end

  // Scan pointer visits one flow per cycle; MAX_FLOW_CNT is a power of two so it wraps by overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_ptr <= '0;
    end else begin
      r_scan_ptr <= r_scan_ptr + 1'b1;
    end
  end

  // Deadline store needs no reset: every read is qualified by the armed bit.
  always_ff @(posedge clk) begin
    if (arm_val) begin
      r_deadline[arm_flowid] <= r_now_tick + arm_timeout;
    end
  end

  // Wrap-safe expiry: the deadline has passed when (now - deadline) lands in the lower half of the tick range.
  always_comb begin
    w_scan_deadline = r_deadline[r_scan_ptr];
    w_age           = r_now_tick - w_scan_deadline;
    w_scan_touched  = (arm_val      && (arm_flowid      == r_scan_ptr)) ||
                      (disarm_val   && (disarm_flowid   == r_scan_ptr)) ||
                      (new_flow_val && (new_flow_flowid == r_scan_ptr));
    w_expire        = r_armed[r_scan_ptr] && !w_age[TIMER_W-1] && !w_scan_touched;
  end

  // Later assignments win, giving new_flow > disarm > arm > expiry clear for a shared flow.
  always_comb begin
    w_armed_nxt = r_armed;
    if (w_expire) begin
      w_armed_nxt[r_scan_ptr] = 1'b0;
    end
    if (arm_val) begin
      w_armed_nxt[arm_flowid] = 1'b1;
    end
    if (disarm_val) begin
      w_armed_nxt[disarm_flowid] = 1'b0;
    end
    if (new_flow_val) begin
      w_armed_nxt[new_flow_flowid] = 1'b0;
    end
  end

  // Armed bits; reset discards every pending timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= '0;
    end else begin
      r_armed <= w_armed_nxt;
    end
  end

  // Register the expiry pulse so it reaches the flag store one cycle after detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_val    <= 1'b0;
      r_to_flowid <= '0;
    end else begin
      r_to_val    <= w_expire;
      r_to_flowid <= w_expire ? r_scan_ptr : '0;
    end
  end

  assign timeout_set_bit_val    = r_to_val;
  assign timeout_set_bit_flowid = r_to_flowid;
  assign now_tick               = r_now_tick;

endmodule
`default_nettype wire

// File: tb/tb_rt_timer_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_rt_timer_scan
// Brief    : Self-checking bench for rt_timer_scan (8 flows, 8-bit ticks,
//            prescale 4). A reference model pushes expected pulses into a
//            queue; a monitor pops and compares them against the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rt_timer_scan;

  localparam int NF = 8;
  localparam int FW = 3;
  localparam int TW = 8;
  localparam int TD = 4;

  logic          clk;
  logic          rst_n;
  logic          arm_val;
  logic [FW-1:0] arm_flowid;
  logic [TW-1:0] arm_timeout;
  logic          disarm_val;
  logic [FW-1:0] disarm_flowid;
  logic          new_flow_val;
  logic [FW-1:0] new_flow_flowid;
  logic          timeout_set_bit_val;
  logic [FW-1:0] timeout_set_bit_flowid;
  logic [TW-1:0] now_tick;

  rt_timer_scan #(
    .MAX_FLOW_CNT(NF),
    .TIMER_W     (TW),
    .TICK_DIV    (TD)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .arm_val               (arm_val),
    .arm_flowid            (arm_flowid),
    .arm_timeout           (arm_timeout),
    .disarm_val            (disarm_val),
    .disarm_flowid         (disarm_flowid),
    .new_flow_val          (new_flow_val),
    .new_flow_flowid       (new_flow_flowid),
    .timeout_set_bit_val   (timeout_set_bit_val),
    .timeout_set_bit_flowid(timeout_set_bit_flowid),
    .now_tick              (now_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int     fid;
    longint due;
  } exp_t;

  exp_t          q[$];
  int            n_assert = 0;
  int            n_fail   = 0;
  longint        cyc      = 0;
  int            cnt[NF];
  int            total;
  int            last_tick;
  int            run_len;
  int            max_run;

  // Reference model state
  bit            m_armed[NF];
  logic [TW-1:0] m_dl[NF];
  logic [TW-1:0] m_now;
  int            m_div;
  int            m_scan;

  // Reference model: advances on each active edge using the inputs held stable since the previous negedge.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < NF; i++) m_armed[i] = 1'b0;
        m_now  = '0;
        m_div  = 0;
        m_scan = 0;
        q.delete();
      end else begin
        bit            touched;
        logic [TW-1:0] age;
        cyc++;
        touched = (arm_val && int'(arm_flowid) == m_scan) ||
                  (disarm_val && int'(disarm_flowid) == m_scan) ||
                  (new_flow_val && int'(new_flow_flowid) == m_scan);
        age = m_now - m_dl[m_scan];
        if (m_armed[m_scan] && (int'(age) < (1 << (TW - 1))) && !touched) begin
          q.push_back('{fid: m_scan, due: cyc});
          m_armed[m_scan] = 1'b0;
        end
        if (arm_val) begin
          m_dl[arm_flowid]    = m_now + arm_timeout;
          m_armed[arm_flowid] = 1'b1;
        end
        if (disarm_val)   m_armed[disarm_flowid]   = 1'b0;
        if (new_flow_val) m_armed[new_flow_flowid] = 1'b0;
        if (m_div == TD - 1) begin
          m_div = 0;
          m_now = m_now + 1'b1;
        end else begin
          m_div = m_div + 1;
        end
        m_scan = (m_scan + 1) % NF;
      end
    end
  end

  // Scoreboard monitor: pops expected pulses and compares them with DUT output away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        n_assert++;
        if (now_tick !== m_now) begin
          n_fail++;
          $display("FAIL now_tick: got %0d, required %0d", now_tick, m_now);
        end
        if (q.size() > 0 && q[0].due < cyc) begin
          n_assert++;
          n_fail++;
          $display("FAIL pulse_missing: got none, required flowid %0d at cycle %0d", q[0].fid, q[0].due);
          void'(q.pop_front());
        end
        if (timeout_set_bit_val === 1'b1) begin
          n_assert++;
          if (q.size() == 0 || q[0].due != cyc || q[0].fid != int'(timeout_set_bit_flowid)) begin
            n_fail++;
            $display("FAIL pulse_unexpected: got flowid %0d at cycle %0d, required %s", timeout_set_bit_flowid, cyc,
                     (q.size() == 0) ? "no pulse" : $sformatf("flowid %0d at cycle %0d", q[0].fid, q[0].due));
          end
          if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
          cnt[timeout_set_bit_flowid]++;
          total++;
          last_tick = int'(now_tick);
          run_len++;
          if (run_len > max_run) max_run = run_len;
        end else begin
          run_len = 0;
          if (q.size() > 0 && q[0].due == cyc) begin
            n_assert++;
            n_fail++;
            $display("FAIL pulse_missing: got none, required flowid %0d at cycle %0d", q[0].fid, q[0].due);
            void'(q.pop_front());
          end
        end
      end
    end
  end

  task automatic clear_counts();
    for (int i = 0; i < NF; i++) cnt[i] = 0;
    total     = 0;
    last_tick = -1;
    run_len   = 0;
    max_run   = 0;
  endtask

  task automatic idle_inputs();
    arm_val         = 1'b0;
    arm_flowid      = '0;
    arm_timeout     = '0;
    disarm_val      = 1'b0;
    disarm_flowid   = '0;
    new_flow_val    = 1'b0;
    new_flow_flowid = '0;
  endtask

  // Called at a negedge; leaves the caller at a negedge.
  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
  endtask

  task automatic do_arm(input int f, input int t);
    arm_val     = 1'b1;
    arm_flowid  = FW'(f);
    arm_timeout = TW'(t);
    @(negedge clk);
    arm_val     = 1'b0;
  endtask

  task automatic do_disarm(input int f);
    disarm_val    = 1'b1;
    disarm_flowid = FW'(f);
    @(negedge clk);
    disarm_val    = 1'b0;
  endtask

  task automatic wait_now(input int t);
    int k;
    k = 0;
    while (int'(m_now) != t && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (int'(m_now) != t) begin
      n_assert++;
      n_fail++;
      $display("FAIL wait_now_timeout: got tick %0d, required %0d", m_now, t);
    end
  endtask

  task automatic wait_scan(input int s);
    int k;
    k = 0;
    while (m_scan != s && k < 2 * NF) begin
      @(negedge clk);
      k++;
    end
    if (m_scan != s) begin
      n_assert++;
      n_fail++;
      $display("FAIL wait_scan_timeout: got scan %0d, required %0d", m_scan, s);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    clear_counts();
    repeat (3) @(negedge clk);
    n_assert += 3;
    if (timeout_set_bit_val !== 1'b0) begin
      n_fail++; $display("FAIL reset_val: got %b, required 0", timeout_set_bit_val);
    end
    if (timeout_set_bit_flowid !== '0) begin
      n_fail++; $display("FAIL reset_flowid: got %0d, required 0", timeout_set_bit_flowid);
    end
    if (now_tick !== '0) begin
      n_fail++; $display("FAIL reset_now_tick: got %0d, required 0", now_tick);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_arm_expire();
    apply_reset();
    do_arm(3, 2);
    repeat (150) @(negedge clk);
    n_assert += 3;
    if (cnt[3] !== 1) begin
      n_fail++; $display("FAIL arm_expire_count: got %0d, required 1", cnt[3]);
    end
    if (total !== 1) begin
      n_fail++; $display("FAIL arm_expire_total: got %0d, required 1", total);
    end
    if ((last_tick >= 2) !== 1'b1) begin
      n_fail++; $display("FAIL arm_expire_tick: got %0d, required >= 2", last_tick);
    end
  endtask

  task automatic test_disarm();
    apply_reset();
    do_arm(1, 5);
    wait_now(3);
    do_disarm(1);
    repeat (200) @(negedge clk);
    n_assert++;
    if (total !== 0) begin
      n_fail++; $display("FAIL disarm_no_pulse: got %0d pulses, required 0", total);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    wait_now(250);
    do_arm(6, 10);
    wait_now(12);
    n_assert += 2;
    if (cnt[6] !== 1 || total !== 1) begin
      n_fail++; $display("FAIL wrap_count: got %0d (total %0d), required 1", cnt[6], total);
    end
    if ((last_tick >= 4 && last_tick <= 6) !== 1'b1) begin
      n_fail++; $display("FAIL wrap_tick: got %0d, required 4..6", last_tick);
    end
  endtask

  task automatic test_disarm_collide();
    apply_reset();
    wait_scan(5);
    do_arm(5, 0);
    wait_scan(5);
    do_disarm(5);
    repeat (50) @(negedge clk);
    n_assert += 2;
    if (cnt[5] !== 0) begin
      n_fail++; $display("FAIL collide_no_pulse: got %0d pulses, required 0", cnt[5]);
    end
    if (dut.r_armed[5] !== 1'b0) begin
      n_fail++; $display("FAIL collide_unarmed: got %b, required 0", dut.r_armed[5]);
    end
  endtask

  task automatic test_rearm();
    apply_reset();
    do_arm(2, 3);
    repeat (3) @(negedge clk);
    do_arm(2, 20);
    wait_now(40);
    n_assert += 2;
    if (cnt[2] !== 1 || total !== 1) begin
      n_fail++; $display("FAIL rearm_count: got %0d (total %0d), required 1", cnt[2], total);
    end
    if ((last_tick >= 21) !== 1'b1) begin
      n_fail++; $display("FAIL rearm_tick: got %0d, required >= 21", last_tick);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < NF; i++) begin
      arm_val     = 1'b1;
      arm_flowid  = FW'(i);
      arm_timeout = '0;
      @(negedge clk);
    end
    arm_val = 1'b0;
    repeat (40) @(negedge clk);
    for (int i = 0; i < NF; i++) begin
      n_assert++;
      if (cnt[i] !== 1) begin
        n_fail++; $display("FAIL b2b_count_%0d: got %0d, required 1", i, cnt[i]);
      end
    end
    n_assert++;
    if (max_run !== NF) begin
      n_fail++; $display("FAIL b2b_run: got %0d consecutive, required %0d", max_run, NF);
    end
  endtask

  task automatic test_reset_midscan();
    apply_reset();
    for (int i = 0; i < NF; i++) begin
      arm_val     = 1'b1;
      arm_flowid  = FW'(i);
      arm_timeout = 8'd1;
      @(negedge clk);
    end
    arm_val = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_assert += 3;
    if (timeout_set_bit_val !== 1'b0) begin
      n_fail++; $display("FAIL midscan_async_val: got %b, required 0", timeout_set_bit_val);
    end
    if (timeout_set_bit_flowid !== '0) begin
      n_fail++; $display("FAIL midscan_async_flowid: got %0d, required 0", timeout_set_bit_flowid);
    end
    if (now_tick !== '0) begin
      n_fail++; $display("FAIL midscan_async_tick: got %0d, required 0", now_tick);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
    repeat (100) @(negedge clk);
    n_assert++;
    if (total !== 0) begin
      n_fail++; $display("FAIL midscan_no_pulse: got %0d pulses, required 0", total);
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_arm_expire();
    test_disarm();
    test_wrap();
    test_disarm_collide();
    test_rearm();
    test_back_to_back();
    test_reset_midscan();
    n_assert++;
    if (q.size() !== 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d pending, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rt_timer_scan.md
# rt_timer_scan

Per-flow retransmit timer that sits directly upstream of the RT/timeout flag store in the send pipe. Holds an armed bit and a deadline for each flow, and advances a prescaled tick clock. A scan pointer visits one flow per cycle. When an armed flow's deadline has passed, the block emits a one-cycle timeout set-bit pulse for that flow, which the flag store latches as `timeout_pending`.

## Interface
- `MAX_FLOW_CNT`, 64: number of flows tracked; power of two.
- `FLOWID_W`, $clog2(MAX_FLOW_CNT): flow ID width.
- `TIMER_W`, 16: tick counter and deadline width.
- `TICK_DIV`, 256: clock cycles per timer tick; ≥1.

Ports:
- `clk`: in, 1. Clock. One clock domain only.
- `rst_n`: in, 1. Reset, asynchronous and active-low.
- `arm_val`: in, 1. Arm or re-arm a flow's timer.
- `arm_flowid`: in, FLOWID_W. Flow to arm.
- `arm_timeout`: in, TIMER_W. Timeout in ticks; must be < 2^(TIMER_W-1).
- `disarm_val`: in, 1. Cancel a flow's timer (all data acked).
- `disarm_flowid`: in, FLOWID_W. Flow to disarm.
- `new_flow_val`: in, 1. Flow allocated; clears its timer.
- `new_flow_flowid`: in, FLOWID_W. Flow being allocated.
- `timeout_set_bit_val`: out, 1. Expiry pulse, one cycle per expiry.
- `timeout_set_bit_flowid`: out, FLOWID_W. Flow that expired.
- `now_tick`: out, TIMER_W. Current tick value, for debug and trace.

## Operation
State:
- Prescaler `div_cnt` counts 0..TICK_DIV-1.
- `now_tick` increments mod 2^TIMER_W in the cycle `div_cnt` == TICK_DIV-1.
- `armed[MAX_FLOW_CNT]`: one bit per flow.
- `deadline[MAX_FLOW_CNT][TIMER_W]`: no reset needed; every read is gated by `armed`.
- `scan_ptr`, FLOWID_W: increments every cycle and wraps MAX_FLOW_CNT-1 → 0.

Arm:
- `deadline[arm_flowid]` <= `now_tick` + `arm_timeout` mod 2^TIMER_W.
- `armed[arm_flowid]` <= 1.
- Re-arming an already armed flow overwrites its deadline.

Disarm and new flow:
- `disarm_val` clears `armed[disarm_flowid]`.
- `new_flow_val` clears `armed[new_flow_flowid]`.

Expiry test for the flow at `scan_ptr`:
- Expired when `armed` is set and (`now_tick` − `deadline`) mod 2^TIMER_W < 2^(TIMER_W-1). This is a wrap-safe compare.
- On expiry, `armed[scan_ptr]` is cleared (one-shot).
- The pulse is registered onto `timeout_set_bit_val`/`timeout_set_bit_flowid` in the next cycle.
- Further pulses for that flow require a new arm.

Simultaneous events:
- Different flows: arm, disarm, new_flow and expiry all take effect in the same cycle.
- Same flow, priority is new_flow > disarm > arm.
- Any arm/disarm/new_flow hitting `scan_ptr` suppresses expiry for that visit. The flow is re-evaluated on the next pass.
- `arm_timeout` = 0: the flow expires on its next scan visit.

Output interface:
- No ready signal; the flag store accepts every cycle.
- At most one pulse per cycle.

## Timing
- Reset (`rst_n` low, asynchronous): clears `div_cnt`, `now_tick`, `armed`, `scan_ptr`, `timeout_set_bit_val`, `timeout_set_bit_flowid`.
  - All outputs read 0 while in reset.
  - Reset mid-scan discards all pending timers; no pulse follows release.
- Arm/disarm/new_flow update state at the clock edge where `*_val` is sampled high. They are visible to the scan in the next cycle.
- Expiry detection: at most MAX_FLOW_CNT cycles after `now_tick` reaches the deadline.
- Pulse latency: +1 cycle after detection.
- Pulse width is exactly 1 cycle; back-to-back pulses for consecutive flows are allowed.
- `now_tick` wraps 2^TIMER_W−1 → 0 with no special handling. The compare covers deadlines up to 2^(TIMER_W-1)−1 ticks ahead.

## Test plan
All scenarios use MAX_FLOW_CNT=8, TIMER_W=8, TICK_DIV=4.
- Arm flow 3, timeout 2, at `now_tick`=0 → exactly one pulse with flowid=3, the cycle after the first `scan_ptr`==3 visit with `now_tick`≥2; no further pulses over 100 cycles.
- Arm flow 1, timeout 5; disarm flow 1 at `now_tick`=3 → no pulse ever.
- Run to `now_tick`=250, arm flow 6, timeout 10 (deadline 4) → no pulse at `now_tick` 251..255 or 0..3; pulse for flowid 6 after `now_tick`=4.
- Flow 5 expired, with `disarm_flowid`=5 asserted in the cycle `scan_ptr`==5 → no pulse; flow 5 stays unarmed.
- Arm flow 2, timeout 3, then re-arm, timeout 20, before expiry → single pulse, only after `now_tick` ≥ second deadline.
- Arm flows 0–7, timeout 1, then drop `rst_n` mid-scan for 2 cycles → outputs 0 asynchronously; zero pulses after release.
